// File: rtl/s1_serial_tx_if.sv
// -----------------------------------------------------------------------------
// s1_serial_tx_if
// Purpose : Bundles the RB1 source-buffer read port and the S2-facing serial
//           link (sen/sd) together with the completion flag of s1_serial_tx.
// Signals :
//   RB1_RW  - RB1 read/write select (1 = read)
//   RB1_A   - RB1 word address, 0..17
//   RB1_D   - RB1 write data (never used for writing)
//   RB1_Q   - RB1 read data, valid the cycle after RB1_A
//   sen     - serial frame enable, active low
//   sd      - serial data bit, valid while sen = 0
//   S1_done - all eight packets sent, sticky until reset
// Modports: master = transmitter side, slave = buffer/receiver side.
// -----------------------------------------------------------------------------
interface s1_serial_tx_if;
   logic       RB1_RW;
   logic [4:0] RB1_A;
   logic [7:0] RB1_D;
   logic [7:0] RB1_Q;
   logic       sen;
   logic       sd;
   logic       S1_done;

   modport master (
      output RB1_RW, RB1_A, RB1_D, sen, sd, S1_done,
      input  RB1_Q
   );

   modport slave (
      input  RB1_RW, RB1_A, RB1_D, sen, sd, S1_done,
      output RB1_Q
   );
endinterface

// File: rtl/s1_serial_tx.sv
// -----------------------------------------------------------------------------
// s1_serial_tx
// Purpose : Reads the 18 x 8-bit buffer RB1, transposes it into eight 18-bit
//           columns and sends each column to S2 as a 21-bit packet
//           (3-bit packet address, then 18 data bits, MSB first) framed by an
//           active-low sen. GAP_CYCLES idle cycles follow every packet.
// Ports   :
//   clk     - system clock, rising edge
//   rst     - synchronous active-high reset
//   tx_hold - (only with S1_TX_HOLD_EN) stretch the inter-packet gap
//   bus     - s1_serial_tx_if.master: RB1 read port, sen/sd, S1_done
// Options :
//   S1_TX_HOLD_EN - when defined, adds the tx_hold input. Holding it high on
//                   the last gap cycle keeps the link idle until it drops.
// Parameter: GAP_CYCLES - idle cycles after every packet, 1..15
// -----------------------------------------------------------------------------
module s1_serial_tx #(
   parameter int GAP_CYCLES = 2
) (
   input  logic           clk,
   input  logic           rst,
`ifdef S1_TX_HOLD_EN
   input  logic           tx_hold,
`endif
   s1_serial_tx_if.master bus
);

   localparam logic [4:0] LOAD_LAST = 5'd18;
   localparam logic [4:0] WORD_LAST = 5'd17;
   localparam logic [4:0] BIT_LAST  = 5'd20;
   localparam logic [2:0] PKT_LAST  = 3'd7;
   localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_SEND,
      ST_GAP,
      ST_DONE
   } state_t;

   state_t     r_state, w_state_next;
   logic [4:0] r_load_cnt, w_load_cnt_next;   // LOAD cycle index 0..18
   logic [4:0] r_word_cnt, w_word_cnt_next;   // RB1 address, saturates at 17
   logic [4:0] r_bit_cnt, w_bit_cnt_next;     // bit currently on sd, 0..20
   logic [3:0] r_gap_cnt, w_gap_cnt_next;
   logic [2:0] r_pkt_cnt, w_pkt_cnt_next;
   logic       r_sen, w_sen_next;
   logic       r_sd, w_sd_next;
   logic       r_done, w_done_next;

   logic            w_hold;
   logic            w_capture;
   logic [4:0]      w_cap_pos;
   logic [7:0][17:0] w_cols;
   logic [2:0]      w_tx_pkt;
   logic [4:0]      w_tx_bit;
   logic [20:0]     w_tx_word;
   logic            w_tx_bit_val;

`ifdef S1_TX_HOLD_EN
   assign w_hold = tx_hold;
`else
   assign w_hold = 1'b0;
`endif

   // --------------------------------------------------------------------------
   // Capture and transpose. Word k arrives during LOAD cycle k+1; its bit j
   // goes straight into column j at position 17-k, so word 0 ends up as the
   // MSB of every column and the packet data can be read out without a
   // separate transpose step.
   // --------------------------------------------------------------------------
   assign w_capture = (r_state == ST_LOAD) && (r_load_cnt != 5'd0);
   assign w_cap_pos = LOAD_LAST - r_load_cnt;

   for (genvar gi = 0; gi < 8; gi++) begin : g_col
      logic [17:0] r_col;

      always_ff @(posedge clk) begin
         if (w_capture) begin
            r_col[w_cap_pos] <= bus.RB1_Q[gi];
         end
      end

      assign w_cols[gi] = r_col;
   end

   // --------------------------------------------------------------------------
   // Bit selection for the next sd value. sd is registered, so at every edge
   // we pick the bit that will be on the wire during the following cycle:
   // the next bit of the current packet while sending, or bit 20 (addr[2])
   // of the upcoming packet when a packet is about to start. On the last
   // LOAD edge only the address bit is needed, so the final captured word
   // does not have to be bypassed.
   // --------------------------------------------------------------------------
   always_comb begin
      w_tx_pkt = r_pkt_cnt;
      w_tx_bit = 5'd0;
      if ((r_state == ST_SEND) && (r_bit_cnt != BIT_LAST)) begin
         w_tx_bit = r_bit_cnt + 5'd1;
      end
      if (r_state == ST_GAP) begin
         w_tx_pkt = r_pkt_cnt + 3'd1;
      end
   end

   assign w_tx_word    = {w_tx_pkt, w_cols[w_tx_pkt]};
   assign w_tx_bit_val = w_tx_word[BIT_LAST - w_tx_bit];

   // --------------------------------------------------------------------------
   // Next-state and next-output logic
   // --------------------------------------------------------------------------
   always_comb begin
      w_state_next    = r_state;
      w_load_cnt_next = r_load_cnt;
      w_word_cnt_next = r_word_cnt;
      w_bit_cnt_next  = r_bit_cnt;
      w_gap_cnt_next  = r_gap_cnt;
      w_pkt_cnt_next  = r_pkt_cnt;
      w_sen_next      = 1'b1;
      w_sd_next       = 1'b0;
      w_done_next     = r_done;

      unique case (r_state)
         ST_LOAD: begin
            if (r_word_cnt != WORD_LAST) begin
               w_word_cnt_next = r_word_cnt + 5'd1;
            end
            if (r_load_cnt == LOAD_LAST) begin
               w_state_next   = ST_SEND;
               w_bit_cnt_next = 5'd0;
               w_sen_next     = 1'b0;
               w_sd_next      = w_tx_bit_val;
            end else begin
               w_load_cnt_next = r_load_cnt + 5'd1;
            end
         end

         ST_SEND: begin
            if (r_bit_cnt == BIT_LAST) begin
               w_state_next   = ST_GAP;
               w_bit_cnt_next = 5'd0;
               w_gap_cnt_next = 4'd0;
            end else begin
               w_bit_cnt_next = r_bit_cnt + 5'd1;
               w_sen_next     = 1'b0;
               w_sd_next      = w_tx_bit_val;
            end
         end

         ST_GAP: begin
            if (r_gap_cnt != GAP_LAST) begin
               w_gap_cnt_next = r_gap_cnt + 4'd1;
            end else if (!w_hold) begin
               // Gap over: either finish or launch the next packet. The
               // packet counter stops at 7 rather than wrapping.
               w_gap_cnt_next = 4'd0;
               if (r_pkt_cnt == PKT_LAST) begin
                  w_state_next = ST_DONE;
                  w_done_next  = 1'b1;
               end else begin
                  w_state_next   = ST_SEND;
                  w_pkt_cnt_next = r_pkt_cnt + 3'd1;
                  w_bit_cnt_next = 5'd0;
                  w_sen_next     = 1'b0;
                  w_sd_next      = w_tx_bit_val;
               end
            end
         end

         ST_DONE: begin
            w_done_next = 1'b1;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // State and output registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_LOAD;
         r_load_cnt <= 5'd0;
         r_word_cnt <= 5'd0;
         r_bit_cnt  <= 5'd0;
         r_gap_cnt  <= 4'd0;
         r_pkt_cnt  <= 3'd0;
         r_sen      <= 1'b1;
         r_sd       <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_load_cnt <= w_load_cnt_next;
         r_word_cnt <= w_word_cnt_next;
         r_bit_cnt  <= w_bit_cnt_next;
         r_gap_cnt  <= w_gap_cnt_next;
         r_pkt_cnt  <= w_pkt_cnt_next;
         r_sen      <= w_sen_next;
         r_sd       <= w_sd_next;
         r_done     <= w_done_next;
      end
   end

   // RB1 is only ever read.
   assign bus.RB1_RW  = 1'b1;
   assign bus.RB1_A   = r_word_cnt;
   assign bus.RB1_D   = 8'h00;
   assign bus.sen     = r_sen;
   assign bus.sd      = r_sd;
   assign bus.S1_done = r_done;

endmodule
